nvram_host_bridge: RTL
======================

Name: nvram_host_bridge

Overview:
- Single-port NVRAM arbiter between the running core and the host ioctl path.
- Downloads with index NV_INDEX write host bytes into RAM; uploads serve RAM bytes on ioctl_din.
- Core writes arriving during a host session are held in a one-entry buffer.
- Tracks a dirty flag and raises an autosave request after core write activity goes idle.

Parameters:
- AW, 9, NVRAM address width (512 bytes).
- NV_INDEX, 8'hff, ioctl_index that selects this NVRAM.
- IDLE_CYCLES, 14318180, clk_sys cycles with no core write before save_req (1 s at 14.318 MHz).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- ioctl_download  in  1  host download session active
- ioctl_upload  in  1  host upload session active
- ioctl_index  in  8  session target index
- ioctl_wr  in  1  download byte strobe, level; the rising edge is the event
- ioctl_addr  in  AW  host byte address
- ioctl_dout  in  8  host write data
- ioctl_din  out  8  upload read data
- core_a  in  AW  core address
- core_d  in  8  core write data
- core_we  in  1  core write, single-cycle pulse
- core_q  out  8  core read data
- ram_a  out  AW  RAM address
- ram_d  out  8  RAM write data
- ram_we  out  1  RAM write enable
- ram_q  in  8  RAM read data, valid 1 cycle after ram_a
- busy  out  1  host session owns the RAM
- dirty  out  1  core has written since the last host sync
- overrun  out  1  sticky: a core write was dropped
- save_req  out  1  1-cycle autosave request pulse

Behaviour:
- Reset (reset_n=0 at a clock edge): ioctl_din=0, core_q=0, ram_we=0, busy=0, dirty=0, overrun=0, save_req=0, pending slot empty, idle counter=0, FSM=IDLE.
- Reset mid-session: the FSM returns to IDLE and the pending slot is discarded.
- A host session is active when (ioctl_download|ioctl_upload) && ioctl_index==NV_INDEX. Sessions with any other index are ignored entirely.
- FSM states: IDLE, HDL, HUL, DRAIN.
- IDLE:
  - ram_a=core_a; ram_we=core_we; ram_d=core_d.
  - core_q is registered from ram_q, giving 2-cycle read latency from core_a.
  - A core write sets dirty and clears the idle counter.
  - Download session → HDL; upload session → HUL; busy=1 from the next cycle.
- HDL:
  - A rising edge of ioctl_wr causes exactly one ram_we cycle with ram_a=ioctl_addr, ram_d=ioctl_dout.
  - A level held on ioctl_wr causes no repeated writes.
  - Session end → DRAIN, and dirty is cleared (the host image is authoritative).
- HUL:
  - ram_a=ioctl_addr continuously and ioctl_din<=ram_q every cycle, so ioctl_din is valid 2 cycles after an ioctl_addr change.
  - Session end → DRAIN, and dirty is cleared.
- DRAIN:
  - If the pending slot is full, perform one ram_we cycle with the pending address/data, set dirty, clear the slot.
  - Then → IDLE with busy=0; busy stays 1 through DRAIN.
- Core write while busy:
  - Slot empty: capture core_a/core_d.
  - Slot full: the write is dropped and overrun=1. overrun stays set until reset.
- core_q holds its last value while busy.
- Session starting in the same cycle as a core_we: the core write is committed that cycle (still IDLE), then the session begins.
- Idle counter:
  - Counts while dirty=1, not busy, and no core_we; saturates at IDLE_CYCLES.
  - When it reaches IDLE_CYCLES, save_req pulses for exactly 1 cycle.
  - No further pulse until a new core write rearms the counter.
  - Cleared whenever dirty is cleared.
- Widths:
  - The idle counter is wide enough for IDLE_CYCLES.
  - ioctl_addr beyond AW is truncated; the upper bits are not ports.

Test Plan:
1. Reset, then core writes 0x5A to 0x010; two cycles later core_a=0x010 → core_q=0x5A, dirty=1.
2. Download with index 0xff writing bytes 0x00..0x1FF (data = low address byte) with ioctl_wr held 3 cycles each → RAM[0x123]=0x23, exactly 512 ram_we pulses; at session end dirty=0.
3. Upload with index 0xff, ioctl_addr stepping 0→511 → ioctl_din equals RAM contents 2 cycles after each address change; download with index 0x00 → no ram_we, busy stays 0.
4. During an upload, core writes 0x77@0x005 then 0x88@0x006 → after the session, RAM[0x005]=0x77, RAM[0x006] unchanged, overrun=1, dirty=1.
5. IDLE_CYCLES=100, one core write, then quiet → save_req high exactly once, 100 cycles later; a further core write rearms it and gives a second pulse 100 cycles after that.
6. reset_n low for 1 cycle mid-upload with the pending slot full → all outputs return to reset values and the pending byte is never written.

Source files
------------

// File: rtl/nvram_host_bridge.sv
`default_nettype none
// nvram_host_bridge -- single-port NVRAM arbiter between the core and the host ioctl
// download/upload path, with a one-entry core write buffer and an idle autosave request.
// Revision: 1.0
module nvram_host_bridge #(
  parameter int         AW          = 9,
  parameter logic [7:0] NV_INDEX    = 8'hff,
  parameter int         IDLE_CYCLES = 14318180
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic [7:0]    ioctl_din,
  input  logic [AW-1:0] core_a,
  input  logic [7:0]    core_d,
  input  logic          core_we,
  output logic [7:0]    core_q,
  output logic [AW-1:0] ram_a,
  output logic [7:0]    ram_d,
  output logic          ram_we,
  input  logic [7:0]    ram_q,
  output logic          busy,
  output logic          dirty,
  output logic          overrun,
  output logic          save_req
);

  localparam int            CW       = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(IDLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HDL   = 2'd1,
    S_HUL   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          wr_q;
  logic          pend_full_q, pend_full_d;
  logic [AW-1:0] pend_a_q, pend_a_d;
  logic [7:0]    pend_data_q, pend_data_d;
  logic          dirty_q, dirty_d;
  logic          overrun_q, overrun_d;
  logic          save_req_q, save_req_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    din_q, din_d;
  logic [7:0]    coreq_q, coreq_d;

  logic session;
  logic wr_rise;
  logic commit;
  logic buffered;
  logic counting;

  assign session = (ioctl_download | ioctl_upload) && (ioctl_index == NV_INDEX);
  assign wr_rise = ioctl_wr & ~wr_q;

  always_comb begin
    state_d     = state_q;
    ram_a       = core_a;
    ram_d       = core_d;
    ram_we      = 1'b0;
    commit      = 1'b0;
    buffered    = 1'b0;
    pend_full_d = pend_full_q;
    pend_a_d    = pend_a_q;
    pend_data_d = pend_data_q;
    dirty_d     = dirty_q;
    overrun_d   = overrun_q;
    din_d       = din_q;
    coreq_d     = coreq_q;

    case (state_q)
      S_IDLE: begin
        ram_we  = core_we;
        commit  = core_we;
        coreq_d = ram_q;
        if (session) state_d = ioctl_download ? S_HDL : S_HUL;
      end
      S_HDL: begin
        ram_a    = ioctl_addr;
        ram_d    = ioctl_dout;
        ram_we   = wr_rise;
        buffered = core_we;
        if (!session) begin
          state_d = S_DRAIN;
          dirty_d = 1'b0;
        end
      end
      S_HUL: begin
        ram_a    = ioctl_addr;
        din_d    = ram_q;
        buffered = core_we;
        if (!session) begin
          state_d = S_DRAIN;
          dirty_d = 1'b0;
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        // An empty slot leaves the port free, so a core write here goes straight to RAM.
        if (pend_full_q) begin
          ram_a       = pend_a_q;
          ram_d       = pend_data_q;
          ram_we      = 1'b1;
          commit      = 1'b1;
          pend_full_d = 1'b0;
          buffered    = core_we;
        end else begin
          ram_we = core_we;
          commit = core_we;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (buffered) begin
      if (pend_full_q) begin
        overrun_d = 1'b1;
      end else begin
        pend_full_d = 1'b1;
        pend_a_d    = core_a;
        pend_data_d = core_d;
      end
    end

    if (commit) dirty_d = 1'b1;

    counting   = (state_q == S_IDLE) && dirty_q && !commit && (cnt_q != CNT_MAX);
    cnt_d      = cnt_q;
    save_req_d = 1'b0;
    if (commit || (dirty_q && !dirty_d)) begin
      cnt_d = '0;
    end else if (counting) begin
      cnt_d      = cnt_q + CW'(1);
      save_req_d = (cnt_q == CNT_LAST);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      pend_full_q <= 1'b0;
      pend_a_q    <= '0;
      pend_data_q <= 8'h00;
      dirty_q     <= 1'b0;
      overrun_q   <= 1'b0;
      save_req_q  <= 1'b0;
      cnt_q       <= '0;
      din_q       <= 8'h00;
      coreq_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      wr_q        <= ioctl_wr;
      pend_full_q <= pend_full_d;
      pend_a_q    <= pend_a_d;
      pend_data_q <= pend_data_d;
      dirty_q     <= dirty_d;
      overrun_q   <= overrun_d;
      save_req_q  <= save_req_d;
      cnt_q       <= cnt_d;
      din_q       <= din_d;
      coreq_q     <= coreq_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign dirty     = dirty_q;
  assign overrun   = overrun_q;
  assign save_req  = save_req_q;
  assign ioctl_din = din_q;
  assign core_q    = coreq_q;

endmodule
`default_nettype wire
